// File: rtl/opl3_pkg.sv
// Shared sizes and per-operator key event state for the key event path.
// Imported by the key event interface, cell and top.
package opl3_pkg;

  localparam int BANK_NUM_WIDTH = 1;
  localparam int OP_NUM_WIDTH = 5;
  localparam int NUM_BANKS = 2;
  localparam int NUM_OPERATORS_PER_BANK = 18;
  localparam int NUM_OPS =
    NUM_BANKS * NUM_OPERATORS_PER_BANK;

  typedef struct packed {
    logic host_key;
    logic pend_on;
    logic pend_off;
  } key_evt_t;

endpackage

// File: rtl/key_event_gen_if.sv
// Host write port plus operator scan port with its key strobes.
// master: register file / scan side, slave: key_event_gen.
interface key_event_gen_if;
  import opl3_pkg::*;

  logic                      wr_en;
  logic [BANK_NUM_WIDTH-1:0] wr_bank;
  logic [OP_NUM_WIDTH-1:0]   wr_op;
  logic                      wr_key_on;
  logic                      sample_clk_en;
  logic [BANK_NUM_WIDTH-1:0] bank_num;
  logic [OP_NUM_WIDTH-1:0]   op_num;
  logic                      key_on_pulse_p0;
  logic                      key_off_pulse_p0;
  logic                      key_level_p0;

  modport master (
    output wr_en, wr_bank, wr_op, wr_key_on,
    output sample_clk_en, bank_num, op_num,
    input  key_on_pulse_p0, key_off_pulse_p0,
    input  key_level_p0
  );

  modport slave (
    input  wr_en, wr_bank, wr_op, wr_key_on,
    input  sample_clk_en, bank_num, op_num,
    output key_on_pulse_p0, key_off_pulse_p0,
    output key_level_p0
  );

endinterface

// File: rtl/key_evt_cell.sv
// One operator's host key bit and pending on/off event flags.
// Ports: wr_hit/wr_val (host write), scan_hit; pulses/level gated by scan_hit.
module key_evt_cell
  import opl3_pkg::*;
#(
  parameter bit DEFER_OFF = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic wr_hit,
  input  logic wr_val,
  input  logic scan_hit,
  output logic key_on_pulse,
  output logic key_off_pulse,
  output logic key_level
);

  key_evt_t st_q;
  key_evt_t st_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st_q <= '0;
    else          st_q <= st_d;
  end

  // Scan consumes first; a same-cycle write lands on top.
  always_comb begin
    st_d = st_q;
    if (scan_hit) begin
      if (st_q.pend_on) begin
        st_d.pend_on = 1'b0;
        if (!DEFER_OFF) st_d.pend_off = 1'b0;
      end else if (st_q.pend_off) begin
        st_d.pend_off = 1'b0;
      end
    end
    if (wr_hit && (wr_val != st_q.host_key)) begin
      st_d.host_key = wr_val;
      if (wr_val) begin
        st_d.pend_on  = 1'b1;
        st_d.pend_off = 1'b0;
      end else begin
        st_d.pend_off = 1'b1;
      end
    end
  end

  assign key_on_pulse  = scan_hit & st_q.pend_on;
  assign key_off_pulse = scan_hit & ~st_q.pend_on
                       & st_q.pend_off;
  assign key_level     = scan_hit & st_q.host_key;

endmodule

// File: rtl/key_event_gen.sv
// Turns asynchronous host key-on writes into scan-aligned key strobes.
// Ports: clk, reset_n, kif (slave: write port, scan index, key outputs).
module key_event_gen
  import opl3_pkg::*;
#(
  parameter bit DEFER_OFF = 1'b1
) (
  input logic       clk,
  input logic       reset_n,
  key_event_gen_if.slave kif
);

  logic [NUM_OPS-1:0] on_v;
  logic [NUM_OPS-1:0] off_v;
  logic [NUM_OPS-1:0] lvl_v;

  // Hits are one-hot, and op indices >= 18 match no cell,
  // so out-of-range writes and scans fall through to zero.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar o = 0; o < NUM_OPERATORS_PER_BANK; o++) begin : g_op
      localparam int IDX = b * NUM_OPERATORS_PER_BANK + o;

      logic wr_hit;
      logic scan_hit;

      assign wr_hit = kif.wr_en
        && (kif.wr_bank == BANK_NUM_WIDTH'(b))
        && (kif.wr_op == OP_NUM_WIDTH'(o));

      assign scan_hit = kif.sample_clk_en
        && (kif.bank_num == BANK_NUM_WIDTH'(b))
        && (kif.op_num == OP_NUM_WIDTH'(o));

      key_evt_cell #(
        .DEFER_OFF (DEFER_OFF)
      ) u_cell (
        .clk           (clk),
        .reset_n       (reset_n),
        .wr_hit        (wr_hit),
        .wr_val        (kif.wr_key_on),
        .scan_hit      (scan_hit),
        .key_on_pulse  (on_v[IDX]),
        .key_off_pulse (off_v[IDX]),
        .key_level     (lvl_v[IDX])
      );
    end
  end

  assign kif.key_on_pulse_p0  = |on_v;
  assign kif.key_off_pulse_p0 = |off_v;
  assign kif.key_level_p0     = |lvl_v;

endmodule

// File: tb/tb_key_event_gen.sv
// Randomized bench for key_event_gen, both DEFER_OFF settings side by side.
// Expected strobes come from a pending-event list model per operator.
module tb_key_event_gen;
  import opl3_pkg::*;

  localparam int EV_NONE   = 0;
  localparam int EV_ON     = 1;
  localparam int EV_OFF    = 2;
  localparam int EV_ON_OFF = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  key_event_gen_if ifa ();
  key_event_gen_if ifb ();

  key_event_gen #(
    .DEFER_OFF (1'b1)
  ) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .kif     (ifa.slave)
  );

  key_event_gen #(
    .DEFER_OFF (1'b0)
  ) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .kif     (ifb.slave)
  );

  int n_chk = 0;
  int n_fail = 0;

  bit host [NUM_OPS];
  int ev_a [NUM_OPS];
  int ev_b [NUM_OPS];

  task automatic check(input string tag,
                       input logic got,
                       input logic want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%b want=%b t=%0t",
               tag, got, want, $time);
    end
  endtask

  task automatic drive(input bit we, input int wb,
                       input int wo, input bit wv,
                       input bit se, input int bn,
                       input int on);
    ifa.wr_en = we;
    ifa.wr_bank = wb[0];
    ifa.wr_op = wo[4:0];
    ifa.wr_key_on = wv;
    ifa.sample_clk_en = se;
    ifa.bank_num = bn[0];
    ifa.op_num = on[4:0];
    ifb.wr_en = we;
    ifb.wr_bank = wb[0];
    ifb.wr_op = wo[4:0];
    ifb.wr_key_on = wv;
    ifb.sample_clk_en = se;
    ifb.bank_num = bn[0];
    ifb.op_num = on[4:0];
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NUM_OPS; i++) begin
      host[i] = 1'b0;
      ev_a[i] = EV_NONE;
      ev_b[i] = EV_NONE;
    end
  endfunction

  // Pop the head of the pending list; without deferral an
  // emitted on swallows the off queued behind it.
  function automatic int pop_ev(input int ev, input bit defer);
    if (ev == EV_ON_OFF && defer) return EV_OFF;
    return EV_NONE;
  endfunction

  // A release queues behind a pending press, otherwise
  // it is the only pending event.
  function automatic int push_off(input int ev);
    if (ev == EV_ON || ev == EV_ON_OFF) return EV_ON_OFF;
    return EV_OFF;
  endfunction

  task automatic cycle(input bit we, input int wb,
                       input int wo, input bit wv,
                       input bit se, input int bn,
                       input int on);
    bit valid;
    int i;
    int w;
    @(negedge clk);
    drive(we, wb, wo, wv, se, bn, on);
    #1;
    valid = se && (on < NUM_OPERATORS_PER_BANK);
    i = valid ? bn * NUM_OPERATORS_PER_BANK + on : 0;
    check("a_on", ifa.key_on_pulse_p0, valid &&
      (ev_a[i] == EV_ON || ev_a[i] == EV_ON_OFF));
    check("a_off", ifa.key_off_pulse_p0,
      valid && ev_a[i] == EV_OFF);
    check("a_lvl", ifa.key_level_p0, valid && host[i]);
    check("b_on", ifb.key_on_pulse_p0, valid &&
      (ev_b[i] == EV_ON || ev_b[i] == EV_ON_OFF));
    check("b_off", ifb.key_off_pulse_p0,
      valid && ev_b[i] == EV_OFF);
    check("b_lvl", ifb.key_level_p0, valid && host[i]);
    @(posedge clk);
    if (valid) begin
      ev_a[i] = pop_ev(ev_a[i], 1'b1);
      ev_b[i] = pop_ev(ev_b[i], 1'b0);
    end
    if (we && wo < NUM_OPERATORS_PER_BANK) begin
      w = wb * NUM_OPERATORS_PER_BANK + wo;
      if (wv != host[w]) begin
        host[w] = wv;
        if (wv) begin
          ev_a[w] = EV_ON;
          ev_b[w] = EV_ON;
        end else begin
          ev_a[w] = push_off(ev_a[w]);
          ev_b[w] = push_off(ev_b[w]);
        end
      end
    end
  endtask

  task automatic scan(input int bn, input int on);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, bn, on);
  endtask

  task automatic wr(input int wb, input int wo, input bit wv);
    cycle(1'b1, wb, wo, wv, 1'b0, 0, 0);
  endtask

  task automatic scan_all();
    for (int b = 0; b < NUM_BANKS; b++)
      for (int o = 0; o < NUM_OPERATORS_PER_BANK; o++)
        scan(b, o);
  endtask

  initial begin
    int wb, wo, bn, on;
    bit we, se;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    model_clear();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    scan_all();

    wr(0, 3, 1'b1);
    scan(0, 3);
    scan(0, 3);

    wr(1, 17, 1'b1);
    wr(1, 17, 1'b0);
    scan(1, 17);
    scan(1, 17);
    scan(1, 17);

    wr(0, 5, 1'b1);
    scan(0, 5);
    wr(0, 5, 1'b0);
    wr(0, 5, 1'b1);
    scan(0, 5);
    scan(0, 5);

    cycle(1'b1, 0, 7, 1'b1, 1'b1, 0, 7);
    scan(0, 7);
    wr(0, 7, 1'b0);
    cycle(1'b1, 0, 7, 1'b1, 1'b1, 0, 7);
    scan(0, 7);
    scan(0, 7);

    cycle(1'b1, 0, 3, 1'b1, 1'b1, 0, 3);
    cycle(1'b1, 0, 20, 1'b1, 1'b1, 0, 20);
    scan(0, 3);
    scan_all();

    for (int n = 0; n < 3000; n++) begin
      we = ($urandom_range(0, 2) == 0);
      wb = $urandom_range(0, 1);
      wo = ($urandom_range(0, 4) == 0) ?
           $urandom_range(0, 21) : $urandom_range(0, 3);
      se = ($urandom_range(0, 7) != 0);
      bn = $urandom_range(0, 1);
      on = ($urandom_range(0, 4) == 0) ?
           $urandom_range(0, 21) : $urandom_range(0, 3);
      cycle(we, wb, wo, 1'($urandom_range(0, 1)),
            se, bn, on);
    end

    for (int o = 0; o < 4; o++)
      wr(0, o, ~host[o]);
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0, 1'b1, 0, 0);
    #1;
    check("pre_rst_evt",
      ifa.key_on_pulse_p0 | ifa.key_off_pulse_p0, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rst_a_on", ifa.key_on_pulse_p0, 1'b0);
    check("rst_a_off", ifa.key_off_pulse_p0, 1'b0);
    check("rst_a_lvl", ifa.key_level_p0, 1'b0);
    check("rst_b_on", ifb.key_on_pulse_p0, 1'b0);
    check("rst_b_off", ifb.key_off_pulse_p0, 1'b0);
    check("rst_b_lvl", ifb.key_level_p0, 1'b0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    scan_all();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
- Sits between the register file and the per-operator envelope generators.
- Captures host key-on register writes, which arrive at arbitrary times, as pending per-operator events.
- Replays those events as single-cycle key_on_pulse_p0 / key_off_pulse_p0 strobes, aligned to the time-multiplexed operator scan.
- Guarantees that no key edge written between two sample periods is lost.

Parameters:
- DEFER_OFF, default 1: when both on and off events are pending, emit on this sample and off next sample. 0 = emit on only and drop the off.
- All sizes come from the package: NUM_BANKS=2, NUM_OPERATORS_PER_BANK=18.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  host key-on register write strobe, one cycle
- wr_bank  in  BANK_NUM_WIDTH  bank of the written operator
- wr_op  in  OP_NUM_WIDTH  operator index of the write
- wr_key_on  in  1  new key-on bit value
- sample_clk_en  in  1  operator scan slot valid
- bank_num  in  BANK_NUM_WIDTH  scanned bank
- op_num  in  OP_NUM_WIDTH  scanned operator
- key_on_pulse_p0  out  1  key-on event for the scanned op, same cycle
- key_off_pulse_p0  out  1  key-off event for the scanned op, same cycle
- key_level_p0  out  1  current host key bit of the scanned op

Behaviour:
- Per-op state, 36 entries:
  - host_key: last written value.
  - pend_on, pend_off: pending-event flags.
  - All three clear on reset_n low, asynchronously. Pending events are discarded on reset mid-operation.
- Outputs:
  - All three are combinational from the current flags, gated by sample_clk_en and index-in-range. Latency 0.
  - All three are 0 when sample_clk_en=0, during reset, or when op_num>=18.
- Write, on wr_en with wr_op<18:
  - host_key<=wr_key_on.
  - 0->1: pend_on<=1, pend_off<=0.
  - 1->0: pend_off<=1, pend_on unchanged.
  - Same value as before: no flag change (a redundant write is not an event).
  - Writes with wr_op>=18 are ignored entirely.
- Scan, on sample_clk_en with valid index:
  - pend_on=1: key_on_pulse_p0=1, key_off_pulse_p0=0; clear pend_on. Clear pend_off only if DEFER_OFF=0.
  - Else pend_off=1: key_off_pulse_p0=1; clear pend_off.
  - Never assert both pulses in one cycle.
- Simultaneous write and scan to the same op in the same cycle:
  - Pulses are computed from pre-write flags.
  - Next state = scan clears applied first, then the write's set/clear applied on top (write wins).
- Sequence summaries:
  - Off->on within one sample: a single on pulse.
  - On->off within one sample (DEFER_OFF=1): on pulse this sample, off pulse on the op's next scan.
- Each pending event produces exactly one pulse. Flags are never set by the scan side.
- Storage: register array, or flops with per-entry set/clear. No RAM, because the write and scan ports must both update flags in the same cycle.

Decomposition:
- Package opl3_pkg: BANK_NUM_WIDTH, OP_NUM_WIDTH, NUM_BANKS, NUM_OPERATORS_PER_BANK; add typedef key_evt_t {host_key, pend_on, pend_off}.
- One sub-module, key_evt_cell:
  - One op's flags.
  - Inputs: write-hit, write value, scan-hit.
  - Outputs: the two pulses and the level.
  - Instantiated via a generate loop over bank×op. The top holds only decode and output mux.

Test Plan:
- Reset release, scan all 36 ops with sample_clk_en=1 -> all pulses and key_level_p0 = 0.
- Write bank0 op3 key=1, scan op3 -> key_on_pulse_p0=1 once, key_level_p0=1. Rescan op3 -> no pulse.
- Write bank1 op17 1 then 0 before its scan, DEFER_OFF=1 -> on pulse first scan, off pulse second scan, third scan none. Repeat with DEFER_OFF=0 -> on only.
- Op5 already on: write 0 then 1 before scan -> single key_on pulse, no off pulse.
- Write op7=1 in the exact cycle op7 is scanned with no prior pending -> no pulse that cycle, on pulse at next op7 scan. Same with op7 pend_off=1 and a write of 1 -> off pulse that cycle, on pulse next scan.
- Redundant write of 1 to an already-on op, and a write with wr_op=20 -> no pulses, no state change.
- Assert reset_n low mid-scan with 4 pending ops -> outputs drop to 0 immediately. After release, no pulses on any op.
